// File: rtl/xgmac_stats.sv
// xgmac_stats: accumulates the 10G MAC per-frame RX/TX statistics vectors
// into live frame/error/byte counters. A snapshot copies every live counter
// into a shadow set, which software reads through a registered read port.
module xgmac_stats #(
    parameter bit C_SATURATE      = 1'b0,
    parameter bit C_CLEAR_ON_SNAP = 1'b1,
    parameter int C_BYTE_W        = 48
) (
    input  logic        clk156,
    input  logic        rst,
    input  logic        rx_statistics_valid,
    input  logic [29:0] rx_statistics_vector,
    input  logic        tx_statistics_valid,
    input  logic [25:0] tx_statistics_vector,
    input  logic        snap_req,
    output logic        snap_done,
    input  logic        rd_en,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid
);

    // Event counter slots: 0 rx_good, 1 rx_bad, 2 rx_fcs, 3 rx_bcast,
    // 4 rx_mcast, 5 tx_good, 6 tx_bad, 7 tx_underrun.
    // Byte counter slots: 0 rx_bytes, 1 tx_bytes.
    localparam int N_EV = 8;

    logic              r_rx_vld;
    logic [18:0]       r_rx_vec;
    logic              r_tx_vld;
    logic [18:0]       r_tx_vec;

    logic [31:0]       r_cnt     [N_EV];
    logic [31:0]       r_cnt_shd [N_EV];
    logic [31:0]       w_next    [N_EV];
    logic [C_BYTE_W-1:0] r_byte     [2];
    logic [C_BYTE_W-1:0] r_byte_shd [2];
    logic [C_BYTE_W-1:0] w_bnext    [2];
    logic [31:0]       r_snap_cnt;

    logic [N_EV-1:0]   w_inc;
    logic [13:0]       w_blen [2];
    logic              w_rx_good;
    logic              w_tx_good;
    logic [31:0]       w_rd_word;
    logic [63:0]       w_rxb64;
    logic [63:0]       w_txb64;

    // Stage 1: register the strobes and the meaningful part of each vector.
    always_ff @(posedge clk156) begin
        if (rst) begin
            r_rx_vld <= 1'b0;
            r_rx_vec <= '0;
            r_tx_vld <= 1'b0;
            r_tx_vec <= '0;
        end else begin
            r_rx_vld <= rx_statistics_valid;
            r_rx_vec <= rx_statistics_vector[18:0];
            r_tx_vld <= tx_statistics_valid;
            r_tx_vec <= tx_statistics_vector[18:0];
        end
    end

    // A frame flagged both good and bad is treated as bad only.
    assign w_rx_good = r_rx_vld & r_rx_vec[0] & ~r_rx_vec[1];
    assign w_tx_good = r_tx_vld & r_tx_vec[0] & ~r_tx_vec[1];

    assign w_inc[0] = w_rx_good;
    assign w_inc[1] = r_rx_vld & r_rx_vec[1];
    assign w_inc[2] = r_rx_vld & r_rx_vec[2];
    assign w_inc[3] = w_rx_good & r_rx_vec[3];
    assign w_inc[4] = w_rx_good & r_rx_vec[4];
    assign w_inc[5] = w_tx_good;
    assign w_inc[6] = r_tx_vld & r_tx_vec[1];
    assign w_inc[7] = r_tx_vld & r_tx_vec[4];

    assign w_blen[0] = w_rx_good ? r_rx_vec[18:5] : 14'd0;
    assign w_blen[1] = w_tx_good ? r_tx_vec[18:5] : 14'd0;

    // Next value of each event counter, wrapping or saturating on overflow.
    generate
        for (genvar gi = 0; gi < N_EV; gi++) begin : g_ev
            logic [32:0] w_sum;
            assign w_sum      = {1'b0, r_cnt[gi]} + 33'(w_inc[gi]);
            assign w_next[gi] = (C_SATURATE && w_sum[32]) ? '1 : w_sum[31:0];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_byte
            logic [C_BYTE_W:0] w_sum;
            assign w_sum       = {1'b0, r_byte[gi]} + (C_BYTE_W+1)'(w_blen[gi]);
            assign w_bnext[gi] = (C_SATURATE && w_sum[C_BYTE_W]) ? '1 : w_sum[C_BYTE_W-1:0];
        end
    endgenerate

    // Stage 2: commit increments; a snapshot captures the post-increment value
    // so the event committing alongside the snapshot lands in the shadow.
    always_ff @(posedge clk156) begin
        if (rst) begin
            for (int i = 0; i < N_EV; i++) begin
                r_cnt[i]     <= '0;
                r_cnt_shd[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                r_byte[i]     <= '0;
                r_byte_shd[i] <= '0;
            end
            r_snap_cnt <= '0;
            snap_done  <= 1'b0;
        end else begin
            snap_done <= snap_req;
            if (snap_req) begin
                r_snap_cnt <= r_snap_cnt + 32'd1;
                for (int i = 0; i < N_EV; i++) begin
                    r_cnt_shd[i] <= w_next[i];
                    r_cnt[i]     <= C_CLEAR_ON_SNAP ? '0 : w_next[i];
                end
                for (int i = 0; i < 2; i++) begin
                    r_byte_shd[i] <= w_bnext[i];
                    r_byte[i]     <= C_CLEAR_ON_SNAP ? '0 : w_bnext[i];
                end
            end else begin
                for (int i = 0; i < N_EV; i++) begin
                    r_cnt[i] <= w_next[i];
                end
                for (int i = 0; i < 2; i++) begin
                    r_byte[i] <= w_bnext[i];
                end
            end
        end
    end

    assign w_rxb64 = 64'(r_byte_shd[0]);
    assign w_txb64 = 64'(r_byte_shd[1]);

    // Read map decode over the shadow registers.
    always_comb begin
        w_rd_word = 32'd0;
        case (rd_addr)
            4'd0:    w_rd_word = r_cnt_shd[0];
            4'd1:    w_rd_word = r_cnt_shd[1];
            4'd2:    w_rd_word = r_cnt_shd[2];
            4'd3:    w_rd_word = r_cnt_shd[3];
            4'd4:    w_rd_word = r_cnt_shd[4];
            4'd5:    w_rd_word = w_rxb64[31:0];
            4'd6:    w_rd_word = w_rxb64[63:32];
            4'd7:    w_rd_word = r_cnt_shd[5];
            4'd8:    w_rd_word = r_cnt_shd[6];
            4'd9:    w_rd_word = r_cnt_shd[7];
            4'd10:   w_rd_word = w_txb64[31:0];
            4'd11:   w_rd_word = w_txb64[63:32];
            4'd12:   w_rd_word = r_snap_cnt;
            default: w_rd_word = 32'd0;
        endcase
    end

    // Registered read port; data holds its last value between reads.
    always_ff @(posedge clk156) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= w_rd_word;
            end
        end
    end

endmodule
